seg_display_ctrl: RTL and testbench

- Parametrised successor to the fixed 3-digit display path (combinational double-dabble, free-running digit scanner).
- Accepts a DATA_W-bit binary value through a valid/ready handshake and converts it to BCD with a sequential shift-add-3 FSM, one bit per cycle.
- Time-multiplexes DIGITS seven-segment digits with a configurable refresh divider.
- Adds leading-zero blanking and an overflow indication; sits between the datapath (register/ALU display value) and the board D1_SEG/D1_AN pins.

---
 rtl/seg_display_ctrl_pkg.sv | 31 +++
 rtl/seg_display_ctrl_if.sv | 21 ++
 rtl/seg_display_ctrl_decode.sv | 27 ++
 rtl/seg_display_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // 2^w-1 has floor(w*log10(2))+1 digits; 2^w is never a power of ten
  function automatic int bcd_digits(input int width);
    longint num;
    num = longint'(width) * 64'sd301029995664;
    return int'(num / 64'sd1000000000000) + 1;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Load handshake between the datapath and the display controller.
// The producer holds valid/data until ready is seen at a clock edge.
interface seg_display_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/seg_display_ctrl_decode.sv
// BCD digit to active-low seven-segment pattern.
// Codes above 9 render as blank.
module seg_decode_7
  import seg_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Binary-to-BCD loader plus multiplexed seven-segment scanner
// with leading-zero blanking and overflow dashes.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  seg_display_ctrl_if.slave  ld,
  input  logic               blank_lz,
  output logic [7:0]         seg,
  output logic [DIGITS-1:0]  an,
  output logic               overflow
);

  localparam int NFULL = bcd_digits(DATA_W);
  localparam int BW    = 4 * NFULL;
  localparam int DW    = 4 * DIGITS;
  localparam int EW    = 4 * (NFULL + DIGITS);
  localparam int CW    = $clog2(DATA_W + 1);
  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0] RST_SEG =
    (ACTIVE_LOW != 0) ? SEG_0 : ~SEG_0;
  localparam logic [DIGITS-1:0] RST_AN =
    (ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [EW-1:0]     bcd_ext;

  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [3:0]        dig [DIGITS];
  logic [DIGITS-1:0] zero_up;
  logic [3:0]        cur_dig;
  logic [7:0]        dec_seg;

  assign ld.load_ready = (state_q == IDLE);
  assign bcd_ext       = EW'(bcd_q);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NFULL; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (ld.load_valid) begin
          sh_d    = ld.load_data;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BW-2:0], sh_q[DATA_W-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d  = bcd_ext[DW-1:0];
        ovf_d   = |(bcd_ext >> DW);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PW'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // zero_up[i]: digit i and everything above it are zero
  always_comb begin
    logic z;
    z       = 1'b1;
    zero_up = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig[i]     = disp_q[4*i +: 4];
      z          = z && (dig[i] == 4'd0);
      zero_up[i] = z;
    end
  end

  assign cur_dig = dig[idx_q];

  seg_decode_7 u_dec (
    .digit_i (cur_dig),
    .seg_o   (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank_lz && idx_q != '0
                 && zero_up[idx_q]) begin
      seg_d = SEG_BLANK;
    end
    an_d = ~(DIGITS'(1) << idx_q);
    if (ACTIVE_LOW == 0) begin
      seg_d = ~seg_d;
      an_d  = ~an_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= RST_SEG;
      an_q  <= RST_AN;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench: two controller configs (3 and 2 digits).
// Loads push expected digit patterns; monitors check after commits.
module tb_seg_display_ctrl;

  typedef struct packed {
    logic [7:0] s2;
    logic [7:0] s1;
    logic [7:0] s0;
    logic       ovf;
    logic [7:0] win;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blz_a = 1'b0;
  logic       blz_b = 1'b0;
  logic [7:0] seg_a, seg_b;
  logic [2:0] an_a;
  logic [1:0] an_b;
  logic       ovf_a, ovf_b;
  int         checks = 0;
  int         errors = 0;
  item_t      qa[$];
  item_t      qb[$];
  logic       busy [2];

  always #5 clk = ~clk;

  seg_display_ctrl_if #(.DATA_W(8)) ifa ();
  seg_display_ctrl_if #(.DATA_W(8)) ifb ();

  seg_display_ctrl #(
    .DATA_W(8), .DIGITS(3),
    .REFRESH_DIV(4), .ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst(rst), .ld(ifa),
    .blank_lz(blz_a), .seg(seg_a),
    .an(an_a), .overflow(ovf_a)
  );

  seg_display_ctrl #(
    .DATA_W(8), .DIGITS(2),
    .REFRESH_DIV(4), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .ld(ifb),
    .blank_lz(blz_b), .seg(seg_b),
    .an(an_b), .overflow(ovf_b)
  );

  function automatic item_t mk(
    logic [7:0] s2, logic [7:0] s1,
    logic [7:0] s0, logic o, int w
  );
    item_t it;
    it.s2 = s2; it.s1 = s1; it.s0 = s0;
    it.ovf = o; it.win = 8'(w);
    return it;
  endfunction

  function automatic logic [2:0] an_of(int u);
    return (u == 0) ? an_a : {1'b1, an_b};
  endfunction

  function automatic logic [7:0] seg_of(int u);
    return (u == 0) ? seg_a : seg_b;
  endfunction

  function automatic logic rdy_of(int u);
    return (u == 0) ? ifa.load_ready : ifb.load_ready;
  endfunction

  function automatic logic ovf_of(int u);
    return (u == 0) ? ovf_a : ovf_b;
  endfunction

  function automatic int idx_of(logic [2:0] a);
    case (a)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic mon(input int u);
    logic       prev, rdy, empty;
    item_t      it;
    logic [7:0] seen [3];
    logic [7:0] ex [3];
    logic [2:0] got;
    int         ix, nd;
    nd   = (u == 0) ? 3 : 2;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      rdy = rdy_of(u);
      if (rdy === 1'b1 && prev === 1'b0) begin
        busy[u] = 1'b1;
        empty = (u == 0) ? (qa.size() == 0)
                         : (qb.size() == 0);
        if (empty) begin
          fail($sformatf("mon%0d_unexpected_commit", u));
        end else begin
          it = (u == 0) ? qa.pop_front()
                        : qb.pop_front();
          ex[0] = it.s0; ex[1] = it.s1; ex[2] = it.s2;
          got = '0;
          @(negedge clk);
          chk($sformatf("mon%0d_overflow", u),
              32'(ovf_of(u)), 32'(it.ovf));
          for (int k = 0; k < int'(it.win); k++) begin
            ix = idx_of(an_of(u));
            if (ix < 0 || ix >= nd) begin
              fail($sformatf("mon%0d_an_onehot got=%b",
                             u, an_of(u)));
            end else if (!got[ix]) begin
              got[ix]  = 1'b1;
              seen[ix] = seg_of(u);
            end
            if (k < int'(it.win) - 1) @(negedge clk);
          end
          for (int d = 0; d < nd; d++) begin
            if (got[d]) begin
              chk($sformatf("mon%0d_digit%0d", u, d),
                  32'(seen[d]), 32'(ex[d]));
            end else if (int'(it.win) >= 4 * nd) begin
              fail($sformatf("mon%0d_digit%0d_unscanned",
                             u, d));
            end
          end
        end
        rdy     = rdy_of(u);
        busy[u] = 1'b0;
      end
      prev = rdy;
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic drive(int u, logic v, logic [7:0] d);
    if (u == 0) begin
      ifa.load_valid = v; ifa.load_data = d;
    end else begin
      ifb.load_valid = v; ifb.load_data = d;
    end
  endtask

  task automatic wait_ready(int u, string nm);
    int n;
    n = 0;
    while (rdy_of(u) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rdy_of(u) !== 1'b1) fail({nm, "_ready_timeout"});
  endtask

  task automatic busy_len(int u, string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy_of(u) !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'd9);
  endtask

  task automatic load(int u, logic [7:0] v, string nm);
    wait_ready(u, nm);
    drive(u, 1'b1, v);
    @(posedge clk);
    #1 drive(u, 1'b0, 8'h00);
    busy_len(u, nm);
  endtask

  task automatic settle();
    repeat (16) @(negedge clk);
  endtask

  function automatic logic [2:0] an_next(logic [2:0] a);
    case (a)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [7:0] seg255(logic [2:0] a);
    return (a == 3'b011) ? 8'hA4 : 8'h92;
  endfunction

  task automatic scan_check();
    logic [2:0] cur;
    int         n, run;
    cur = an_a;
    n   = 0;
    while (an_a == cur && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (an_a == cur) fail("scan_no_advance");
    for (int r = 0; r < 4; r++) begin
      cur = an_a;
      chk($sformatf("scan_seg_run%0d", r),
          32'(seg_a), 32'(seg255(cur)));
      run = 0;
      while (an_a == cur && run < 10) begin
        run++;
        @(negedge clk);
      end
      chk($sformatf("scan_hold_run%0d", r),
          32'(run), 32'd4);
      chk($sformatf("scan_order_run%0d", r),
          32'(an_a), 32'(an_next(cur)));
    end
  endtask

  initial begin
    int n;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_an_a", 32'(an_a), 32'b110);
    chk("rst_seg_a", 32'(seg_a), 32'hC0);
    chk("rst_ready_a", 32'(ifa.load_ready), 32'd1);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_an_b", 32'(an_b), 32'b10);
    chk("rst_seg_b", 32'(seg_b), 32'hC0);

    qa.push_back(mk(8'hA4, 8'h92, 8'h92, 1'b0, 12));
    load(0, 8'd255, "ld255");
    scan_check();
    settle();

    blz_a = 1'b1;
    qa.push_back(mk(8'hFF, 8'hFF, 8'hF8, 1'b0, 12));
    load(0, 8'd7, "ld7");
    settle();
    qa.push_back(mk(8'hFF, 8'hFF, 8'hC0, 1'b0, 12));
    load(0, 8'd0, "ld0");
    settle();
    qa.push_back(mk(8'hF9, 8'hC0, 8'h92, 1'b0, 12));
    load(0, 8'd105, "ld105");
    settle();
    qa.push_back(mk(8'hFF, 8'hF9, 8'hC0, 1'b0, 12));
    load(0, 8'd10, "ld10");
    settle();
    blz_a = 1'b0;
    qa.push_back(mk(8'hF9, 8'hA4, 8'h80, 1'b0, 12));
    load(0, 8'd128, "ld128");
    settle();

    qa.push_back(mk(8'hC0, 8'h99, 8'hA4, 1'b0, 8));
    qa.push_back(mk(8'hC0, 8'hF9, 8'hF8, 1'b0, 12));
    wait_ready(0, "ld42");
    drive(0, 1'b1, 8'd42);
    @(posedge clk);
    #1 drive(0, 1'b1, 8'd17);
    busy_len(0, "ld42");
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ld17_accepted", 32'(ifa.load_ready), 32'd0);
    wait_ready(0, "ld17");
    settle();

    qa.push_back(mk(8'hC0, 8'hC0, 8'hC0, 1'b0, 12));
    wait_ready(0, "ld200");
    drive(0, 1'b1, 8'd200);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(ifa.load_ready), 32'd1);
    chk("midrst_ovf", 32'(ovf_a), 32'd0);
    settle();

    qb.push_back(mk(8'h00, 8'hBF, 8'hBF, 1'b1, 8));
    load(1, 8'd100, "b_ld100");
    settle();
    qb.push_back(mk(8'h00, 8'h90, 8'h90, 1'b0, 8));
    load(1, 8'd99, "b_ld99");
    settle();
    qb.push_back(mk(8'h00, 8'hBF, 8'hBF, 1'b1, 8));
    load(1, 8'd255, "b_ld255");
    settle();
    blz_b = 1'b1;
    qb.push_back(mk(8'h00, 8'hFF, 8'h92, 1'b0, 8));
    load(1, 8'd5, "b_ld5");
    settle();

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 ||
            busy[0] || busy[1]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0)
      fail("scoreboard_not_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
